// File: rtl/frame_ram_arbiter_pkg.sv
// Shared definitions for the frame RAM arbiter: FSM encodings and the 160x120
// frame geometry also used by the downsampler.
package frame_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_HOLD    = 2'b11
  } arb_state_e;

  localparam int ARB_FRAME_W      = 160;
  localparam int ARB_FRAME_H      = 120;
  localparam int ARB_FRAME_PIXELS = ARB_FRAME_W * ARB_FRAME_H;

endpackage

// File: rtl/frame_ram_arbiter_wr_fifo.sv
// Synchronous write buffer holding {addr, data} entries for the frame RAM.
// Push is accepted on full when a pop happens in the same cycle; flush empties it.
module frame_ram_arbiter_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Camera-to-frame-RAM write arbiter with read priority for the VGA side.
// Optional macro ARB_DROP_COUNT_EN adds the DROP_CNT output.
//   state   | meaning
//   IDLE    | disabled, buffer flushed
//   ARMED   | waiting for the first VSYNC, buffer drains
//   CAPTURE | camera writes accepted
//   HOLD    | frozen image, buffer drains, new writes ignored
module frame_ram_arbiter
  import frame_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = ARB_FRAME_PIXELS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              FREEZE,
  input  logic              FRAME_START,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WE,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [1:0]        STATE,
  output logic [7:0]        FRAME_CNT,
`ifdef ARB_DROP_COUNT_EN
  output logic [15:0]       DROP_CNT,
`endif
  output logic              OVERFLOW
);

  localparam int LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0] PIX_LIM = LIM_W'(FRAME_PIXELS);

  arb_state_e               state_q;
  logic [7:0]               frame_cnt_q;
  logic                     overflow_q, rd_valid_q;
  logic [ADDR_W-1:0]        ram_addr_q;
  logic [DATA_W-1:0]        ram_wdata_q;
  logic [ADDR_W+DATA_W-1:0] head;
  logic                     fifo_full, fifo_empty;
  logic                     wr_ok, pop, drop, ovf_clr;

  assign wr_ok   = WR_REQ && (state_q == ST_CAPTURE) && ({1'b0, WR_ADDR} < PIX_LIM);
  assign pop     = !RD_REQ && !fifo_empty;
  assign drop    = ENABLE && wr_ok && fifo_full && !pop;
  assign ovf_clr = FRAME_START && (state_q == ST_CAPTURE);

  frame_ram_arbiter_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wr_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .flush_i (!ENABLE),
    .push_i  (wr_ok),
    .wdata_i ({WR_ADDR, WR_DATA}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reads win the RAM port outright; otherwise drain the buffer, else hold the bus.
  assign RAM_WE    = pop;
  assign RAM_ADDR  = RD_REQ ? RD_ADDR : (pop ? head[ADDR_W+DATA_W-1:DATA_W] : ram_addr_q);
  assign RAM_WDATA = pop ? head[DATA_W-1:0] : ram_wdata_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_valid_q ? RAM_RDATA : '0;
  assign STATE     = state_q;
  assign FRAME_CNT = frame_cnt_q;
  assign OVERFLOW  = overflow_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      rd_valid_q  <= RD_REQ;
      ram_addr_q  <= RAM_ADDR;
      ram_wdata_q <= RAM_WDATA;
      if (!ENABLE) begin
        state_q     <= ST_IDLE;
        frame_cnt_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        overflow_q <= (ovf_clr ? 1'b0 : overflow_q) | drop;
        case (state_q)
          ST_IDLE:  state_q <= ST_ARMED;
          ST_ARMED: if (FRAME_START) state_q <= ST_CAPTURE;
          ST_CAPTURE: if (FRAME_START) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            if (FREEZE) state_q <= ST_HOLD;
          end
          ST_HOLD:  if (FRAME_START && !FREEZE) state_q <= ST_CAPTURE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ARB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  assign DROP_CNT = drop_cnt_q;

  // Cleared on exactly the same events that clear OVERFLOW.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_q <= '0;
    end else if (!ENABLE) begin
      drop_cnt_q <= '0;
    end else if (ovf_clr) begin
      drop_cnt_q <= {15'd0, drop};
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: per-cycle vector table plus hand-written
// sequences for overflow, freeze, ENABLE-drop and reset during a read.
module tb_frame_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N, ENABLE, FREEZE, FRAME_START, WR_REQ, RD_REQ;
  logic [14:0] WR_ADDR, RD_ADDR, RAM_ADDR;
  logic [7:0]  WR_DATA, RD_DATA, RAM_WDATA, RAM_RDATA, FRAME_CNT;
  logic        RD_VALID, RAM_WE, OVERFLOW;
  logic [1:0]  STATE;
`ifdef ARB_DROP_COUNT_EN
  logic [15:0] DROP_CNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  frame_ram_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FREEZE(FREEZE),
    .FRAME_START(FRAME_START), .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WE(RAM_WE), .RAM_RDATA(RAM_RDATA),
    .STATE(STATE), .FRAME_CNT(FRAME_CNT),
`ifdef ARB_DROP_COUNT_EN
    .DROP_CNT(DROP_CNT),
`endif
    .OVERFLOW(OVERFLOW)
  );

  typedef struct {
    logic en, fs, frz, wr;
    logic [14:0] wa;
    logic [7:0] wd;
    logic rd;
    logic [14:0] ra;
    logic [7:0] rdat;
    logic [1:0] st;
    logic we;
    logic [14:0] addr;
    logic [7:0] wdat;
    logic rv;
    logic [7:0] rdd;
    logic [7:0] fc;
    logic ov;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic en, fs, frz, wr, input int wa, wd,
                              input logic rd, input int ra, rdat, st,
                              input logic we, input int addr, wdat,
                              input logic rv, input int rdd, fc, input logic ov);
    vec_t v;
    v.en = en; v.fs = fs; v.frz = frz; v.wr = wr;
    v.wa = 15'(wa); v.wd = 8'(wd); v.rd = rd; v.ra = 15'(ra); v.rdat = 8'(rdat);
    v.st = 2'(st); v.we = we; v.addr = 15'(addr); v.wdat = 8'(wdat);
    v.rv = rv; v.rdd = 8'(rdd); v.fc = 8'(fc); v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  task automatic drv(input logic en, fs, frz, wr, input int wa, wd, input logic rd, input int ra);
    ENABLE = en; FRAME_START = fs; FREEZE = frz; WR_REQ = wr;
    WR_ADDR = 15'(wa); WR_DATA = 8'(wd); RD_REQ = rd; RD_ADDR = 15'(ra);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            en fs fz wr wa     wd     rd ra   rdat  | st we addr   wdat   rv rdd   fc ov
    tbl[0]  = mk(0, 0, 0, 0, 0,     0,     0, 0,   0,      0, 0, 0,     0,     0, 0,    0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      0, 0, 0,     0,     0, 0,    0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      1, 0, 0,     0,     0, 0,    0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 50,    'h11,  0, 0,   0,      1, 0, 0,     0,     0, 0,    0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0,     0,     0, 0,   0,      1, 0, 0,     0,     0, 0,    0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 100,   'hE0,  0, 0,   0,      2, 0, 0,     0,     0, 0,    0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      2, 1, 100,   'hE0,  0, 0,    0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      2, 0, 100,   'hE0,  0, 0,    0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 19200, 'hAA,  1, 300, 0,      2, 0, 300,   'hE0,  0, 0,    0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 19199, 'hBB,  1, 301, 'h33,   2, 0, 301,   'hE0,  1, 'h33, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,     0,     0, 0,   'h44,   2, 1, 19199, 'hBB,  1, 'h44, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,     0,     0, 0,   'h55,   2, 0, 19199, 'hBB,  0, 0,    0, 0);
    tbl[12] = mk(1, 1, 0, 0, 0,     0,     0, 0,   0,      2, 0, 19199, 'hBB,  0, 0,    0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      2, 0, 19199, 'hBB,  0, 0,    1, 0);
    tbl[14] = mk(1, 1, 1, 0, 0,     0,     0, 0,   0,      2, 0, 19199, 'hBB,  0, 0,    1, 0);
    tbl[15] = mk(1, 0, 0, 1, 7,     'h77,  0, 0,   0,      3, 0, 19199, 'hBB,  0, 0,    2, 0);
    tbl[16] = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      3, 0, 19199, 'hBB,  0, 0,    2, 0);
    tbl[17] = mk(1, 1, 0, 0, 0,     0,     0, 0,   0,      3, 0, 19199, 'hBB,  0, 0,    2, 0);
    tbl[18] = mk(1, 0, 0, 0, 0,     0,     0, 0,   0,      2, 0, 19199, 'hBB,  0, 0,    2, 0);
    tbl[19] = mk(0, 0, 0, 0, 0,     0,     0, 0,   0,      2, 0, 19199, 'hBB,  0, 0,    2, 0);
    tbl[20] = mk(0, 0, 0, 0, 0,     0,     0, 0,   0,      0, 0, 19199, 'hBB,  0, 0,    0, 0);

    RST_N = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    RAM_RDATA = 8'h5A;
    #23;
    @(negedge CLK);
    chk("rst_state", STATE, 0);
    chk("rst_we", RAM_WE, 0);
    chk("rst_addr", RAM_ADDR, 0);
    chk("rst_wdata", RAM_WDATA, 0);
    chk("rst_rv", RD_VALID, 0);
    chk("rst_rdata", RD_DATA, 0);
    chk("rst_fc", FRAME_CNT, 0);
    chk("rst_ov", OVERFLOW, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].en, tbl[i].fs, tbl[i].frz, tbl[i].wr, int'(tbl[i].wa), int'(tbl[i].wd),
          tbl[i].rd, int'(tbl[i].ra));
      RAM_RDATA = tbl[i].rdat;
      @(negedge CLK);
      chk($sformatf("v%0d_state", i), STATE, tbl[i].st);
      chk($sformatf("v%0d_we", i), RAM_WE, tbl[i].we);
      chk($sformatf("v%0d_addr", i), RAM_ADDR, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), RAM_WDATA, tbl[i].wdat);
      chk($sformatf("v%0d_rv", i), RD_VALID, tbl[i].rv);
      chk($sformatf("v%0d_rdata", i), RD_DATA, tbl[i].rdd);
      chk($sformatf("v%0d_fc", i), FRAME_CNT, tbl[i].fc);
      chk($sformatf("v%0d_ov", i), OVERFLOW, tbl[i].ov);
      tick();
    end
    RAM_RDATA = 8'h00;

    // Overflow: six writes under a ten-cycle read burst, four retained.
    drv(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, (i < 6), 1000 + i, i, 1, 500 + i);
      @(negedge CLK);
      chk($sformatf("burst%0d_we", i), RAM_WE, 0);
      chk($sformatf("burst%0d_addr", i), RAM_ADDR, 500 + i);
      if (i > 0) chk($sformatf("burst%0d_rv", i), RD_VALID, 1);
      tick();
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      if (j == 0) chk("burst_rv_tail", RD_VALID, 1);
      if (j == 1) chk("burst_rv_end", RD_VALID, 0);
      chk($sformatf("drain%0d_we", j), RAM_WE, 1);
      chk($sformatf("drain%0d_addr", j), RAM_ADDR, 1000 + j);
      chk($sformatf("drain%0d_wdata", j), RAM_WDATA, j);
      tick();
    end
    @(negedge CLK);
    chk("drain_done_we", RAM_WE, 0);
    chk("ovf_sticky", OVERFLOW, 1);
`ifdef ARB_DROP_COUNT_EN
    chk("drop_cnt", DROP_CNT, 2);
`endif
    tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("ovf_cleared", OVERFLOW, 0);
    chk("fc_after_clr", FRAME_CNT, 1);
`ifdef ARB_DROP_COUNT_EN
    chk("drop_cnt_cleared", DROP_CNT, 0);
`endif
    tick();

    // Full buffer with a simultaneous pop accepts the push.
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 1, 2000 + i, 'h40 + i, 1, 0); tick();
    end
    drv(1, 0, 0, 1, 2004, 'h44, 0, 0);
    @(negedge CLK);
    chk("fullpop_we", RAM_WE, 1);
    chk("fullpop_addr", RAM_ADDR, 2000);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge CLK);
      chk($sformatf("fp_drain%0d_addr", j), RAM_ADDR, 2000 + j);
      chk($sformatf("fp_drain%0d_we", j), RAM_WE, 1);
      tick();
    end
    @(negedge CLK);
    chk("fullpop_no_ovf", OVERFLOW, 0);
    tick();

    // ENABLE drop beats FRAME_START and flushes two queued entries.
    drv(1, 0, 0, 1, 3000, 1, 1, 10); tick();
    drv(1, 0, 0, 1, 3001, 2, 1, 11); tick();
    drv(0, 1, 0, 0, 0, 0, 1, 12); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("dis_state", STATE, 0);
    chk("dis_fc", FRAME_CNT, 0);
    chk("dis_flushed_we", RAM_WE, 0);
    tick();
    @(negedge CLK);
    chk("dis_flushed_we2", RAM_WE, 0);
    tick();

    // Reset asserted while a read is in flight.
    RAM_RDATA = 8'h99;
    drv(0, 0, 0, 0, 0, 0, 1, 42); tick();
    chk("inflight_rv", RD_VALID, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_rv", RD_VALID, 0);
    chk("rst_mid_rdata", RD_DATA, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_state", STATE, 0);
    chk("post_rst_rv", RD_VALID, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
